// File: rtl/cbus_sram_bridge.sv
`default_nettype none
// ============================================================================
// cbus_sram_bridge : CBus master port to RAMHelper bridge (FIXED/INCR/WRAP
//                    bursts, region decode, MMIO timer, unsupported flag).
// Revision: 1.0
// ============================================================================

package cbus_pkg;
    localparam logic [2:0] MSIZE8      = 3'd3;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_sram_bridge
    import cbus_pkg::*;
#(
    parameter int unsigned LATENCY     = 0,
    parameter int unsigned IDX_WIDTH   = 26,
    parameter logic [3:0]  MEM_NIBBLE  = 4'h8,
    parameter int unsigned TICK_DIV    = 10000,
    parameter logic [63:0] TIMER_ADDR  = 64'h3800_bff8,
    parameter logic [63:0] TIMER_ALIAS = 64'h2000_3000,
    parameter logic [63:0] STATUS_ADDR = 64'h4060_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  cbus_req_t   oreq,
    output cbus_resp_t  oresp,
    output logic [63:0] rIdx,
    input  logic [63:0] rdata,
    output logic [63:0] wIdx,
    output logic [63:0] wdata,
    output logic [63:0] wmask,
    output logic        wen,
    output logic        en,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam int unsigned    DLY_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DLY_W-1:0] DLY_INIT = (LATENCY > 0) ? DLY_W'(LATENCY - 1) : '0;
    localparam logic [31:0]    PRESC_MAX = 32'(TICK_DIV - 1);

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic [DLY_W-1:0]  dly, dly_n;
    logic [63:0]       mtime;
    logic [31:0]       presc;

    logic [63:0]       step, incr_addr, wrap_mask, beat_addr;
    logic              unsupported;
    logic              is_ram, is_timer, is_status;

    // Beat address: WRAP keeps the aligned block base and wraps the offset.
    always_comb begin
        step      = {53'd0, cnt, 3'd0};
        incr_addr = oreq.addr + step;
        wrap_mask = {53'd0, oreq.len, 3'b111};
        case (oreq.burst)
            BURST_INCR: beat_addr = incr_addr;
            BURST_WRAP: beat_addr = (oreq.addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    beat_addr = oreq.addr;
        endcase
    end

    always_comb begin
        unsupported = 1'b0;
        if (!(oreq.burst inside {BURST_FIXED, BURST_INCR, BURST_WRAP}))
            unsupported = 1'b1;
        if ((oreq.burst == BURST_INCR || oreq.burst == BURST_WRAP) &&
            oreq.size != MSIZE8 && oreq.len != 8'd0)
            unsupported = 1'b1;
        if (oreq.burst == BURST_WRAP &&
            !(oreq.len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            unsupported = 1'b1;
    end

    assign is_ram    = (beat_addr[31:28] == MEM_NIBBLE);
    assign is_timer  = (beat_addr == TIMER_ADDR) || (beat_addr == TIMER_ALIAS);
    assign is_status = (beat_addr == STATUS_ADDR);

    assign rIdx  = 64'(beat_addr[IDX_WIDTH+2:3]);
    assign wIdx  = rIdx;
    assign wdata = oreq.data;
    assign en    = 1'b1;

    for (genvar i = 0; i < 8; i++) begin : g_wmask
        assign wmask[i*8 +: 8] = {8{oreq.strobe[i]}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            dly   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dly   <= dly_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        dly_n       = dly;
        oresp       = '0;
        wen         = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                if (oreq.valid) begin
                    cnt_n = '0;
                    if (unsupported) begin
                        state_n = ERR;
                    end else if (LATENCY > 0) begin
                        state_n = WAIT;
                        dly_n   = DLY_INIT;
                    end else begin
                        state_n = BURST;
                    end
                end
            end
            WAIT: begin
                if (dly == '0) state_n = BURST;
                else           dly_n   = dly - 1'b1;
            end
            BURST: begin
                oresp.ready = 1'b1;
                oresp.last  = (cnt == oreq.len);
                // Status sits ahead of the timer so an overlapping address reads 0.
                if (is_ram)         oresp.data = rdata;
                else if (is_status) oresp.data = '0;
                else if (is_timer)  oresp.data = mtime;
                else                oresp.data = '0;
                wen   = oreq.is_write & is_ram;
                cnt_n = cnt + 8'd1;
                if (oresp.last) state_n = IDLE;
            end
            ERR: begin
                oresp.ready = 1'b1;
                oresp.last  = 1'b1;
                err         = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Free-running timer, independent of bus activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            mtime <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            mtime <= mtime + 64'd1;
        end else begin
            presc <= presc + 32'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cbus_sram_bridge.sv
`default_nettype none
// ============================================================================
// tb_cbus_sram_bridge : scoreboard bench for cbus_sram_bridge (two instances,
//                       LATENCY 0 and 5, TICK_DIV 4).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps

module tb_cbus_sram_bridge;
    import cbus_pkg::*;

    localparam int unsigned TDIV   = 4;
    localparam logic [2:0]  MS4    = 3'd2;
    localparam logic [2:0]  MS8    = 3'd3;
    localparam logic [1:0]  FIXED  = 2'd0;
    localparam logic [1:0]  INCR   = 2'd1;
    localparam logic [1:0]  WRAP   = 2'd2;
    localparam logic [63:0] T_ADDR = 64'h3800_bff8;
    localparam logic [63:0] T_ALI  = 64'h2000_3000;
    localparam logic [63:0] S_ADDR = 64'h4060_0008;

    typedef struct {
        int          cyc;
        logic        last;
        logic [63:0] data;
        logic [63:0] idx;
        logic        chk_idx;
        logic        wen;
        logic [63:0] wmask;
        logic [63:0] wdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic sel;
    cbus_req_t  req, req0, req1;
    cbus_resp_t resp0, resp1;
    logic [63:0] ridx0, ridx1, widx0, widx1, wd0, wd1, wm0, wm1, rd0, rd1;
    logic wen0, wen1, en0, en1, err0, err1;

    logic        m_ready, m_last, m_wen, m_err;
    logic [63:0] m_data, m_ridx, m_widx, m_wmask, m_wdata;

    int   cyc = 0;
    int   tcnt;
    int   vecs = 0;
    int   miscmp = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge reset)
        if (reset) tcnt <= 0;
        else       tcnt <= tcnt + 1;

    always_comb begin
        req0 = req;
        req0.valid = req.valid & ~sel;
        req1 = req;
        req1.valid = req.valid & sel;
    end

    // RAM word k holds k.
    assign rd0 = ridx0;
    assign rd1 = ridx1;

    cbus_sram_bridge #(.LATENCY(0), .TICK_DIV(TDIV)) u_dut0 (
        .clk(clk), .reset(reset), .oreq(req0), .oresp(resp0), .rIdx(ridx0),
        .rdata(rd0), .wIdx(widx0), .wdata(wd0), .wmask(wm0), .wen(wen0),
        .en(en0), .err(err0));

    cbus_sram_bridge #(.LATENCY(5), .TICK_DIV(TDIV)) u_dut1 (
        .clk(clk), .reset(reset), .oreq(req1), .oresp(resp1), .rIdx(ridx1),
        .rdata(rd1), .wIdx(widx1), .wdata(wd1), .wmask(wm1), .wen(wen1),
        .en(en1), .err(err1));

    always_comb begin
        m_ready = sel ? resp1.ready : resp0.ready;
        m_last  = sel ? resp1.last  : resp0.last;
        m_data  = sel ? resp1.data  : resp0.data;
        m_ridx  = sel ? ridx1 : ridx0;
        m_widx  = sel ? widx1 : widx0;
        m_wmask = sel ? wm1   : wm0;
        m_wdata = sel ? wd1   : wd0;
        m_wen   = sel ? wen1  : wen0;
        m_err   = sel ? err1  : err0;
    end

    // Monitor: every beat / write / error pulse consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (m_ready || m_wen || m_err)) begin
            vecs++;
            if (sbq.size() == 0) begin
                miscmp++;
                $display("FAIL unexpected_beat cyc=%0d ready=%b wen=%b err=%b idx=%h", cyc, m_ready, m_wen, m_err, m_ridx);
            end else begin
                e = sbq.pop_front();
                if (!m_ready || cyc != e.cyc || m_last != e.last || m_data != e.data ||
                    (e.chk_idx && (m_ridx != e.idx || m_widx != e.idx)) || m_wen != e.wen ||
                    m_wmask != e.wmask || m_wdata != e.wdata || m_err != e.err) begin
                    miscmp++;
                    $display("FAIL beat got cyc=%0d rdy=%b last=%b data=%h ridx=%h widx=%h wen=%b wmask=%h wdata=%h err=%b want cyc=%0d last=%b data=%h idx=%h wen=%b wmask=%h wdata=%h err=%b",
                             cyc, m_ready, m_last, m_data, m_ridx, m_widx, m_wen, m_wmask, m_wdata, m_err,
                             e.cyc, e.last, e.data, e.idx, e.wen, e.wmask, e.wdata, e.err);
                end
            end
        end
    end

    function automatic logic [63:0] mask_of(input logic [7:0] s);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic wait_done();
        bit done = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (m_ready && m_last) done = 1'b1;
        end
        if (!done) begin
            vecs++;
            miscmp++;
            $display("FAIL timeout got no last beat want last within 60 cycles");
        end
        @(posedge clk); #1;
        req.valid = 1'b0;
    endtask

    task automatic issue(input bit s, input bit wr, input logic [2:0] sz, input logic [63:0] a,
                         input logic [7:0] strb, input logic [63:0] d, input logic [7:0] ln,
                         input logic [1:0] bt);
        int lat, ic, tnow, bc;
        bit bad;
        exp_t e;
        logic [63:0] ba, base, bytes;
        lat = s ? 5 : 0;
        @(posedge clk); #1;
        sel = s;
        req.is_write = wr; req.size = sz; req.addr = a; req.strobe = strb;
        req.data = d; req.len = ln; req.burst = bt; req.valid = 1'b1;
        ic = cyc;
        tnow = tcnt;
        bad = (bt == 2'd3) || (bt != FIXED && sz != MS8 && ln != 8'd0) ||
              (bt == WRAP && !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15));
        e.wmask = mask_of(strb);
        e.wdata = d;
        if (bad) begin
            e.cyc = ic + 1; e.last = 1'b1; e.data = '0; e.idx = '0; e.chk_idx = 1'b0;
            e.wen = 1'b0; e.err = 1'b1;
            sbq.push_back(e);
        end else begin
            for (int k = 0; k <= int'(ln); k++) begin
                if (bt == FIXED)     ba = a;
                else if (bt == INCR) ba = a + 64'(k) * 64'd8;
                else begin
                    bytes = (64'(ln) + 64'd1) * 64'd8;
                    base  = a - (a % bytes);
                    ba    = base + ((a - base + 64'(k) * 64'd8) % bytes);
                end
                bc = ic + lat + 1 + k;
                e.cyc = bc;
                e.last = (k == int'(ln));
                e.idx = (ba >> 3) & 64'h3FF_FFFF;
                e.chk_idx = 1'b1;
                e.err = 1'b0;
                e.wen = wr && (ba[31:28] == 4'h8);
                if (ba[31:28] == 4'h8)                   e.data = e.idx;
                else if (ba == S_ADDR)                   e.data = '0;
                else if (ba == T_ADDR || ba == T_ALI)    e.data = 64'((tnow + (bc - ic)) / TDIV);
                else                                     e.data = '0;
                sbq.push_back(e);
            end
        end
        wait_done();
    endtask

    task automatic check_quiet(input string name);
        vecs++;
        if (m_ready || m_last || m_wen || m_err || m_data != 64'd0) begin
            miscmp++;
            $display("FAIL %s got ready=%b last=%b wen=%b err=%b data=%h want all zero", name, m_ready, m_last, m_wen, m_err, m_data);
        end
    endtask

    initial begin
        #300_000;
        $display("FAIL watchdog got no end of run want completion before 300us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        sel = 1'b0;
        req = '0;
        #2;
        check_quiet("reset_dut0");
        sel = 1'b1; #1;
        check_quiet("reset_dut1");
        vecs++;
        if (!(en0 && en1)) begin
            miscmp++;
            $display("FAIL en got %b%b want 11", en0, en1);
        end
        sel = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        issue(0, 0, MS8, 64'h8000_0000, 8'hFF, 64'h0, 8'd3, INCR);          // idx 0..3
        issue(1, 1, MS8, 64'h8000_0010, 8'h0F, 64'h1122334455667788, 8'd0, FIXED);
        issue(0, 0, MS8, 64'h8000_0018, 8'hFF, 64'h0, 8'd3, WRAP);          // idx 3,0,1,2
        issue(0, 0, MS8, 64'h8000_0030, 8'hFF, 64'h0, 8'd7, WRAP);          // idx 6,7,0..5
        issue(0, 1, MS8, 64'h8000_0100, 8'h81, 64'hDEAD_BEEF_0BAD_F00D, 8'd1, INCR);
        issue(0, 0, MS4, 64'h8000_0008, 8'h0F, 64'h0, 8'd2, INCR);          // err
        issue(1, 0, MS4, 64'h8000_0008, 8'h0F, 64'h0, 8'd2, INCR);          // err, LATENCY 5
        issue(0, 0, MS8, 64'h8000_0008, 8'hFF, 64'h0, 8'd2, WRAP);          // err, len+1=3
        issue(0, 0, MS8, 64'h8000_0008, 8'hFF, 64'h0, 8'd0, 2'd3);          // err, bad burst
        issue(0, 0, MS4, 64'h8000_0020, 8'h0F, 64'h0, 8'd0, INCR);          // single narrow beat ok
        issue(0, 0, MS8, 64'h1000_0000, 8'hFF, 64'h0, 8'd1, INCR);          // unmapped reads 0
        issue(0, 1, MS8, 64'h1000_0000, 8'hFF, 64'h55, 8'd0, FIXED);        // unmapped write dropped

        // Reset during beat 2 of an 8-beat write.
        @(posedge clk); #1;
        sel = 1'b0;
        req.is_write = 1'b1; req.size = MS8; req.addr = 64'h8000_0200; req.strobe = 8'hFF;
        req.data = 64'hA5A5_5A5A_0123_4567; req.len = 8'd7; req.burst = INCR; req.valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e.cyc = cyc + 1 + k; e.last = 1'b0; e.idx = 64'h40 + 64'(k); e.data = e.idx;
            e.chk_idx = 1'b1; e.wen = 1'b1; e.err = 1'b0; e.wmask = '1; e.wdata = req.data;
            sbq.push_back(e);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_quiet("reset_midburst");
        req.valid = 1'b0;
        @(negedge clk);
        check_quiet("reset_hold");
        @(posedge clk); #1;
        reset = 1'b0;
        issue(0, 0, MS8, 64'h8000_0000, 8'hFF, 64'h0, 8'd1, INCR);          // restarts at beat 0

        // Timer: read TIMER_ADDR so the beat lands 41 cycles after reset (mtime 10).
        for (int t = 0; t < 100 && tcnt < 39; t++) @(posedge clk);
        #1;
        issue(0, 0, MS8, T_ADDR, 8'hFF, 64'h0, 8'd0, FIXED);
        issue(0, 0, MS8, T_ALI,  8'hFF, 64'h0, 8'd0, FIXED);
        issue(0, 0, MS8, S_ADDR, 8'hFF, 64'h0, 8'd0, FIXED);
        issue(0, 1, MS8, T_ADDR, 8'hFF, 64'h99, 8'd0, FIXED);
        issue(1, 0, MS8, T_ALI,  8'hFF, 64'h0, 8'd0, FIXED);

        repeat (5) @(posedge clk);
        vecs++;
        if (sbq.size() != 0) begin
            miscmp++;
            $display("FAIL scoreboard_drain got %0d pending beats want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cbus_sram_bridge.md
# cbus_sram_bridge

Parametrised CBus-to-SRAM bridge connecting the core's CBus master port to the simulation RAMHelper. It supports FIXED, INCR and WRAP bursts with a programmable first-beat latency and a memory-region decode. It also provides an MMIO timer with a programmable tick divider and a flag for unsupported requests. It replaces the single-mode bridge in the simulation top-level.

## Interface

Parameters:
- LATENCY, 0: idle cycles inserted between request acceptance and the first beat.
- IDX_WIDTH, 26: RAM word-index width; index = beat_addr[IDX_WIDTH+2:3], zero-extended to 64 bits.
- MEM_NIBBLE, 4'h8: addr[31:28] value that selects RAM.
- TICK_DIV, 10000: clock cycles per timer increment; must be ≥ 1.
- TIMER_ADDR, 64'h3800_bff8: primary timer read address.
- TIMER_ALIAS, 64'h2000_3000: alias timer read address.
- STATUS_ADDR, 64'h4060_0008: status register address; always reads 0.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- oreq  in  cbus_req_t  request: valid, is_write, size, addr, strobe, data, len, burst
- oresp  out  cbus_resp_t  response: ready, last, data
- rIdx  out  64  RAM read index
- rdata  in  64  RAM read data, combinational on rIdx
- wIdx  out  64  RAM write index; equals rIdx
- wdata  out  64  equals oreq.data
- wmask  out  64  byte i of wmask = {8{oreq.strobe[i]}}
- wen  out  1  RAM write enable
- en  out  1  constant 1
- err  out  1  one-cycle pulse on an unsupported request

## Operation

- Master rule: oreq is held stable from valid rising until the cycle in which ready and last are both high.
- FSM states: IDLE, WAIT, BURST, ERR.
- IDLE, oreq.valid = 1:
  - Unsupported request → ERR. Unsupported means: burst is not FIXED/INCR/WRAP; INCR/WRAP with size ≠ MSIZE8 and len > 0; or WRAP with len+1 ∉ {2,4,8,16}.
  - Otherwise → WAIT with dly = LATENCY − 1 when LATENCY > 0, else → BURST.
  - cnt is cleared.
- WAIT: dly decrements each cycle; at dly = 0 → BURST.
- BURST:
  - ready = 1 every cycle; cnt increments after each beat.
  - last = (cnt == len); on last → IDLE.
- ERR: ready = last = 1 and data = 0 for one cycle, err = 1, no write; → IDLE.
- Beat address:
  - FIXED: addr.
  - INCR: addr + cnt·8.
  - WRAP: bytes = (len+1)·8; base = addr & ~(bytes−1); beat = base | ((addr + cnt·8) & (bytes−1)).
- Region decode on the beat address:
  - RAM: addr[31:28] == MEM_NIBBLE.
  - MMIO: addr equals TIMER_ADDR, TIMER_ALIAS or STATUS_ADDR.
  - Anything else is unmapped.
- Read data in BURST: RAM → rdata; timer addresses → mtime; STATUS_ADDR → 0; unmapped → 0. Outside BURST/ERR, oresp.data = 0.
- wen = (state == BURST) & is_write & RAM region. Writes to MMIO or unmapped addresses are dropped and still acknowledged.
- Timer: 64-bit mtime plus a 32-bit prescaler. Prescaler counts 0..TICK_DIV−1; on wrap, mtime increments and wraps at 2^64. The timer runs independently of the FSM.

## Timing

- Reset, asynchronous: state = IDLE, cnt = dly = 0, mtime = prescaler = 0. Immediately: ready = last = err = wen = 0, data = 0. Reset mid-burst abandons the burst with no further writes.
- First beat occurs LATENCY+1 cycles after the first cycle valid is seen in IDLE. A burst of len+1 beats completes in LATENCY+1+len+1 cycles, including the return to IDLE.
- After last, the FSM spends at least one cycle in IDLE before accepting the next request (no back-to-back beats).
- Each beat writes in the same cycle ready is high. rIdx/wIdx follow the beat address combinationally.
- mtime is read at the beat cycle, with no snapshot across the burst.
- ERR response occurs exactly one cycle after acceptance, regardless of LATENCY.

## Test plan

- LATENCY=0, INCR len=3 read at 0x8000_0000 with RAM word k = k → ready high for 4 consecutive cycles; data 0,1,2,3 with rIdx 0..3; last only on beat 4; first beat 1 cycle after valid.
- LATENCY=5, FIXED write addr 0x8000_0010, strobe 0x0F, data 0x1122334455667788 → one wen pulse 6 cycles after valid; wIdx = 2; wmask = 0x0000_0000_FFFF_FFFF; ready = last = 1 in that cycle.
- WRAP len=3 at 0x8000_0018 → rIdx sequence 3,0,1,2; last on rIdx 2.
- TICK_DIV=4: read TIMER_ADDR at cycle 41 after reset → data 10; read TIMER_ALIAS the same; STATUS_ADDR → 0; a write to TIMER_ADDR → wen stays 0, still acked.
- INCR len=2 with size MSIZE4 → err = 1 for one cycle; ready = last = 1 with data 0 on the cycle after valid; no wen.
- Assert reset during beat 2 of an INCR len=7 write → outputs go to 0 immediately; no wen after reset; the next request starts from beat 0.
